// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, execute redirect
// and the decode-side instruction handshake.
interface instruction_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imemReqValid;
  logic            imemReqReady;
  logic [XLEN-1:0] imemReqAddr;
  logic            imemRespValid;
  logic [XLEN-1:0] imemRespData;
  logic            redirectValid;
  logic [XLEN-1:0] redirectTarget;
  logic            decodeReady;
  logic            instrValid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instrPc;
  logic [6:0]      opcode;

  modport master (
    output imemReqValid, imemReqAddr, instrValid, instr, instrPc, opcode,
    input  imemReqReady, imemRespValid, imemRespData,
           redirectValid, redirectTarget, decodeReady
  );

  modport slave (
    input  imemReqValid, imemReqAddr, instrValid, instr, instrPc, opcode,
    output imemReqReady, imemRespValid, imemRespData,
           redirectValid, redirectTarget, decodeReady
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: credit-limited fetch PC, in-order response
// buffering with request-PC tracking, and redirect flush with stale-response drain.
module instruction_fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input logic                   clk,
  input logic                   reset,
  instruction_fetch_unit_if.master bus
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  typedef enum logic {FETCH, DRAIN} state_e;
  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  cnt_t            out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
  ptr_t            head_q, head_d, tail_q, tail_d;
  ptr_t            pcq_head_q, pcq_head_d, pcq_tail_q, pcq_tail_d;
  logic            req_valid_q, req_valid_d;
  logic [XLEN-1:0] buf_data_q [BUF_DEPTH];
  logic [XLEN-1:0] buf_data_d [BUF_DEPTH];
  logic [XLEN-1:0] buf_pc_q   [BUF_DEPTH];
  logic [XLEN-1:0] buf_pc_d   [BUF_DEPTH];
  logic [XLEN-1:0] pcq_q      [BUF_DEPTH];
  logic [XLEN-1:0] pcq_d      [BUF_DEPTH];

  logic            accept, resp_take, pop, instr_valid;
  logic [CW:0]     credit_used;
  logic            unused_tgt_bits;

  assign instr_valid     = (cnt_q != '0);
  assign unused_tgt_bits = ^bus.redirectTarget[1:0];

  always_comb begin
    accept      = req_valid_q && bus.imemReqReady;
    resp_take   = (state_q == FETCH) && bus.imemRespValid && (out_q != '0);
    pop         = instr_valid && bus.decodeReady;
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    out_d       = out_q;
    drop_d      = drop_q;
    cnt_d       = cnt_q;
    head_d      = head_q;
    tail_d      = tail_q;
    pcq_head_d  = pcq_head_q;
    pcq_tail_d  = pcq_tail_q;
    buf_data_d  = buf_data_q;
    buf_pc_d    = buf_pc_q;
    pcq_d       = pcq_q;

    if (bus.redirectValid) begin
      fetch_pc_d = {bus.redirectTarget[XLEN-1:2], 2'b00};
      head_d     = '0;
      tail_d     = '0;
      pcq_head_d = '0;
      pcq_tail_d = '0;
      cnt_d      = '0;
      out_d      = '0;
      // Requests still in memory (including one accepted now) must be drained.
      if (state_q == FETCH)
        drop_d = out_q + cnt_t'(accept) - cnt_t'(resp_take);
      else if (bus.imemRespValid && (drop_q != '0))
        drop_d = drop_q - 1'b1;
      state_d = (drop_d != '0) ? DRAIN : FETCH;
    end else if (state_q == DRAIN) begin
      if (bus.imemRespValid && (drop_q != '0))
        drop_d = drop_q - 1'b1;
      if (drop_d == '0)
        state_d = FETCH;
    end else begin
      if (accept) begin
        pcq_d[pcq_tail_q] = fetch_pc_q;
        pcq_tail_d        = pcq_tail_q + 1'b1;
        fetch_pc_d        = fetch_pc_q + XLEN'(4);
      end
      if (resp_take) begin
        buf_data_d[tail_q] = bus.imemRespData;
        buf_pc_d[tail_q]   = pcq_q[pcq_head_q];
        tail_d             = tail_q + 1'b1;
        pcq_head_d         = pcq_head_q + 1'b1;
      end
      if (pop)
        head_d = head_q + 1'b1;
      out_d = out_q + cnt_t'(accept) - cnt_t'(resp_take);
      cnt_d = cnt_q + cnt_t'(resp_take) - cnt_t'(pop);
    end

    credit_used = {1'b0, out_d} + {1'b0, cnt_d};
    req_valid_d = (state_d == FETCH) && (credit_used < (CW+1)'(BUF_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH;
      fetch_pc_q  <= RESET_PC;
      out_q       <= '0;
      drop_q      <= '0;
      cnt_q       <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      pcq_head_q  <= '0;
      pcq_tail_q  <= '0;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      out_q       <= out_d;
      drop_q      <= drop_d;
      cnt_q       <= cnt_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      pcq_head_q  <= pcq_head_d;
      pcq_tail_q  <= pcq_tail_d;
      req_valid_q <= req_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_data_q <= buf_data_d;
    buf_pc_q   <= buf_pc_d;
    pcq_q      <= pcq_d;
  end

  assign bus.imemReqValid = req_valid_q;
  assign bus.imemReqAddr  = fetch_pc_q;
  assign bus.instrValid   = instr_valid;
  assign bus.instr        = instr_valid ? buf_data_q[head_q] : '0;
  assign bus.instrPc      = instr_valid ? buf_pc_q[head_q]   : '0;
  assign bus.opcode       = instr_valid ? buf_data_q[head_q][6:0] : '0;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed + random bench for instruction_fetch_unit: behavioural memory with
// in-order variable latency and a sequential-PC reference for delivered instructions.
module tb_instruction_fetch_unit;
  localparam int          XLEN      = 32;
  localparam int          BUF_DEPTH = 2;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instruction_fetch_unit_if #(.XLEN(XLEN)) bus ();

  instruction_fetch_unit #(
    .XLEN(XLEN), .RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0, errors = 0;
  int cyc = 0, since_rst = 0, first_valid = -1, first_req = -1;
  int accepts = 0, pops = 0, mem_extra = 0;
  bit model_on = 0, after_reset = 0, expect_empty = 0, block_ready = 0;
  bit const_mem = 1, rand_mem = 0;
  logic [31:0] exp_pc = RESET_PC, exp_req = RESET_PC;
  logic [31:0] mem_addr[$];
  int          mem_due[$];
  logic [31:0] acc_log[$], pop_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    h = a * 32'h9E37_79B1;
    if (const_mem) return 32'h0000_0013;
    return {h[31:7], a[8:2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_log(input string tag, input logic [31:0] q[$], input int idx,
                         input logic [31:0] expv);
    logic [31:0] v;
    v = 'x;
    if (idx < q.size()) v = q[idx];
    chk(tag, v, expv);
  endtask

  task automatic step(input bit rdy, input bit dec, input bit redir,
                      input logic [31:0] tgt, input bit rst);
    bit          resp;
    logic [31:0] w;
    reset              = rst;
    bus.imemReqReady   = rdy && !block_ready && !rst;
    bus.decodeReady    = dec;
    bus.redirectValid  = redir;
    bus.redirectTarget = tgt;
    resp = (mem_addr.size() != 0) && (mem_due[0] <= cyc) &&
           (!rand_mem || $urandom_range(0, 3) != 0);
    bus.imemRespValid = resp;
    bus.imemRespData  = resp ? mem_word(mem_addr[0]) : $urandom;
    @(negedge clk);
    if (model_on) begin
      if (after_reset)  chk("reset_req_valid", 32'(bus.imemReqValid), 32'd0);
      if (expect_empty) chk("flush_instr_valid", 32'(bus.instrValid), 32'd0);
      if (!bus.instrValid) begin
        chk("idle_instr", bus.instr, 32'd0);
        chk("idle_pc", bus.instrPc, 32'd0);
        chk("idle_opcode", 32'(bus.opcode), 32'd0);
      end else begin
        w = mem_word(exp_pc);
        chk("instr_pc", bus.instrPc, exp_pc);
        chk("instr_word", bus.instr, w);
        chk("opcode", 32'(bus.opcode), {25'd0, w[6:0]});
      end
      if (bus.imemReqValid) chk("req_addr", bus.imemReqAddr, exp_req);
    end
    if (resp) begin
      void'(mem_addr.pop_front());
      void'(mem_due.pop_front());
    end
    if (!rst) begin
      if (bus.imemReqValid && bus.imemReqReady) begin
        mem_addr.push_back(bus.imemReqAddr);
        mem_due.push_back(cyc + 1 + (rand_mem ? int'($urandom_range(0, mem_extra)) : mem_extra));
        acc_log.push_back(bus.imemReqAddr);
        if (first_req < 0) first_req = since_rst;
        accepts++;
        exp_req += 32'd4;
        chk("inflight_cap", (mem_addr.size() <= BUF_DEPTH) ? 32'd1 : 32'd0, 32'd1);
      end
      if (bus.instrValid && first_valid < 0) first_valid = since_rst;
      if (bus.instrValid && bus.decodeReady) begin
        pop_log.push_back(bus.instrPc);
        pops++;
        exp_pc += 32'd4;
      end
      if (redir) begin
        exp_pc  = {tgt[31:2], 2'b00};
        exp_req = exp_pc;
      end
      since_rst++;
    end else begin
      exp_pc      = RESET_PC;
      exp_req     = RESET_PC;
      since_rst   = 0;
      first_valid = -1;
      first_req   = -1;
      model_on    = 1;
    end
    after_reset  = rst;
    expect_empty = rst || redir;
    block_ready  = (mem_addr.size() != 0) && (block_ready || rst);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    bus.imemReqReady   = 1'b0;
    bus.imemRespValid  = 1'b0;
    bus.imemRespData   = '0;
    bus.redirectValid  = 1'b0;
    bus.redirectTarget = '0;
    bus.decodeReady    = 1'b0;
    @(posedge clk);
    #1;
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);

    // Streaming from reset with a 1-cycle memory returning NOPs.
    acc_log.delete(); pop_log.delete();
    for (int i = 0; i < 20; i++) step(1, 1, 0, '0, 0);
    chk("first_req_cycle", 32'(first_req), 32'd1);
    chk("first_valid_cycle", 32'(first_valid), 32'd3);
    chk_log("seq_addr0", acc_log, 0, 32'h0);
    chk_log("seq_addr1", acc_log, 1, 32'h4);
    chk_log("seq_addr2", acc_log, 2, 32'h8);
    chk_log("seq_addr3", acc_log, 3, 32'hC);
    chk_log("seq_pc1", pop_log, 1, 32'h4);

    // Decode back-pressure: credits cap the requests at the buffer depth.
    step(0, 0, 0, '0, 1);
    const_mem = 0;
    accepts = 0; pops = 0; acc_log.delete(); pop_log.delete();
    for (int i = 0; i < 8; i++) step(1, 0, 0, '0, 0);
    chk("stall_accepts", 32'(accepts), 32'd2);
    chk("stall_pops", 32'(pops), 32'd0);
    chk("stall_held_valid", 32'(bus.instrValid), 32'd1);
    for (int i = 0; i < 4; i++) step(1, 1, 0, '0, 0);
    chk_log("release_pc0", pop_log, 0, 32'h0);
    chk_log("release_pc1", pop_log, 1, 32'h4);

    // Redirect with one request still in memory.
    step(0, 0, 0, '0, 1);
    mem_extra = 2;
    step(1, 1, 0, '0, 0);
    step(1, 1, 0, '0, 0);
    acc_log.delete(); pop_log.delete();
    step(0, 1, 1, 32'h0000_0102, 0);
    chk("redir_drain_reqv", 32'(bus.imemReqValid), 32'd0);
    for (int i = 0; i < 12; i++) step(1, 1, 0, '0, 0);
    chk_log("redir_addr", acc_log, 0, 32'h100);
    chk_log("redir_first_pc", pop_log, 0, 32'h100);
    mem_extra = 0;

    // Redirect coinciding with a pop and the last outstanding response.
    step(0, 0, 0, '0, 1);
    step(1, 1, 0, '0, 0);
    step(1, 1, 0, '0, 0);
    step(1, 0, 0, '0, 0);
    acc_log.delete(); pop_log.delete();
    step(0, 1, 1, 32'h0000_0200, 0);
    chk("drain_skip_reqv", 32'(bus.imemReqValid), 32'd1);
    for (int i = 0; i < 6; i++) step(1, 1, 0, '0, 0);
    chk_log("same_cycle_pop", pop_log, 0, 32'h0);
    chk_log("same_cycle_next_pc", pop_log, 1, 32'h200);
    chk_log("same_cycle_addr", acc_log, 0, 32'h200);

    // Address wrap at the top of the address space.
    step(1, 1, 1, 32'hFFFF_FFFC, 0);
    acc_log.delete(); pop_log.delete();
    for (int i = 0; i < 10; i++) step(1, 1, 0, '0, 0);
    chk_log("wrap_addr0", acc_log, 0, 32'hFFFF_FFFC);
    chk_log("wrap_addr1", acc_log, 1, 32'h0);
    chk_log("wrap_pc0", pop_log, 0, 32'hFFFF_FFFC);
    chk_log("wrap_pc1", pop_log, 1, 32'h0);

    // Reset with two requests in flight; their late replies must be ignored.
    step(0, 0, 0, '0, 1);
    mem_extra = 3;
    step(1, 1, 1, 32'h0000_0400, 0);
    step(1, 1, 0, '0, 0);
    step(1, 1, 0, '0, 0);
    chk("rst_inflight", 32'(mem_addr.size()), 32'd2);
    step(1, 1, 0, '0, 1);
    mem_extra = 0;
    acc_log.delete(); pop_log.delete();
    for (int i = 0; i < 14; i++) step(1, 1, 0, '0, 0);
    chk_log("rst_first_addr", acc_log, 0, RESET_PC);
    chk_log("rst_first_pc", pop_log, 0, RESET_PC);
    chk("rst_valid_latency", 32'(first_valid), 32'(first_req + 2));

    // Random traffic: memory latency, back-pressure, redirects and resets.
    rand_mem = 1;
    mem_extra = 3;
    for (int i = 0; i < 1500; i++) begin
      bit          r, d;
      logic [31:0] t;
      r = ($urandom_range(0, 299) == 0);
      d = ($urandom_range(0, 24) == 0) && !r;
      t = $urandom;
      if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, d, t, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
